ps2_keyboard_mmio: RTL and testbench

//  Memory-mapped keyboard input responder. It is the read-side counterpart of the CPU's ASCII/VGA store path.

---
 rtl/ps2_kbd_pkg.sv | 32 +++
 rtl/ps2_rx_frame.sv | 93 +++++++++
 rtl/ps2_keyboard_mmio.sv | 169 ++++++++++++++++
 tb/tb_ps2_keyboard_mmio.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard MMIO responder: register map, bit indices,
// store-size encodings and the frame receiver state type.
package ps2_kbd_pkg;

  localparam logic [3:0] REG_STATUS = 4'h0;
  localparam logic [3:0] REG_DATA   = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_FRAME_ERR = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned CTRL_RX_EN  = 0;
  localparam int unsigned CTRL_CLEAR  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam logic [1:0] WM_NONE = 2'b00;
  localparam logic [1:0] WM_BYTE = 2'b01;
  localparam logic [1:0] WM_HALF = 2'b10;
  localparam logic [1:0] WM_WORD = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw lines, samples on ps2_clk falling edges,
// checks odd parity and stop bit, and abandons stalled frames after TIMEOUT_CYCLES.
module ps2_rx_frame
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);

  rx_state_e      state_q;
  logic [1:0]     clk_sync_q, dat_sync_q;
  logic           clk_prev_q;
  logic [7:0]     shift_q;
  logic [2:0]     bit_cnt_q;
  logic           parity_q;
  logic [ToW-1:0] to_cnt_q;
  logic           fall, dat;

  assign fall = clk_prev_q & ~clk_sync_q[1];
  assign dat  = dat_sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Lines idle high, so the synchronisers start at 1 to avoid a false edge.
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= StIdle;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      parity_q   <= 1'b0;
      to_cnt_q   <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_prev_q <= clk_sync_q[1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state_q == StIdle || fall) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + ToW'(1);

      if (state_q != StIdle && !fall && to_cnt_q == ToLast) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            bit_cnt_q <= 3'd0;
            if (fall && !dat) state_q <= StData;
            else if (!dat)    state_q <= StStart;
          end
          StStart: begin
            bit_cnt_q <= 3'd0;
            if (fall) state_q <= dat ? StIdle : StData;
          end
          StData: if (fall) begin
            shift_q   <= {dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: if (fall) begin
            parity_q <= dat;
            state_q  <= StStop;
          end
          StStop: if (fall) begin
            state_q <= StIdle;
            if (dat && (^{shift_q, parity_q})) begin
              rx_byte    <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_mmio.sv
// Memory-mapped PS/2 keyboard responder: scan-code FIFO plus STATUS/DATA/CTRL registers
// behind the data-memory handshake. Define PS2_KBD_IRQ_EN to add the irq output.
module ps2_keyboard_mmio
  import ps2_kbd_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0007_1000,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [1:0]  write_mode,
  input  logic [7:0]  write_byte,
  input  logic [15:0] write_half_word,
  input  logic [31:0] write_word,
  output logic [7:0]  byte_output,
  output logic [15:0] half_word_output,
  output logic [31:0] word_output,
  output logic        done,
  output logic        error,
  input  logic        ps2_clk,
  input  logic        ps2_dat
`ifdef PS2_KBD_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      rx_byte;
  logic            rx_valid, rx_frame_err;
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            overflow_q, frame_err_q, rx_en_q, irq_en, done_q, error_q;
  logic [7:0]      byte_q;
  logic [15:0]     half_q;
  logic [31:0]     word_q, wdata, rd_word;
  logic            in_win, store_req, store_fire, misalign, empty, full;
  logic            pop_req, ctrl_wr, push_req, do_pop, do_push, ovf_set;
  logic            unused_wdata;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .rx_byte   (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_frame_err)
  );

  always_comb begin
    in_win   = address[31:4] == BASE_ADDR[31:4];
    misalign = 1'b0;
    wdata    = 32'h0;
    case (write_mode)
      WM_BYTE: wdata = {24'h0, write_byte};
      WM_HALF: begin
        wdata    = {16'h0, write_half_word};
        misalign = address[0];
      end
      WM_WORD: begin
        wdata    = write_word;
        misalign = address[1:0] != 2'b00;
      end
      default: ;
    endcase
    store_req  = in_win && write_mode != WM_NONE;
    // Side effects only on the first sampled cycle of a store.
    store_fire = store_req && !done_q && !misalign;
    pop_req    = store_fire && address[3:2] == REG_DATA[3:2];
    ctrl_wr    = store_fire && address[3:2] == REG_CTRL[3:2];

    empty    = count_q == '0;
    full     = count_q == CntW'(FIFO_DEPTH);
    push_req = rx_valid && rx_en_q;
    do_pop   = pop_req && !empty;
    do_push  = push_req && (!full || do_pop);
    ovf_set  = push_req && full && !do_pop;

    rd_word = 32'h0;
    if (address[3:2] == REG_STATUS[3:2]) begin
      rd_word[ST_NOT_EMPTY]        = !empty;
      rd_word[ST_FULL]             = full;
      rd_word[ST_OVERFLOW]         = overflow_q;
      rd_word[ST_FRAME_ERR]        = frame_err_q;
      rd_word[ST_COUNT_LSB +: 5]   = 5'(count_q);
    end else if (address[3:2] == REG_DATA[3:2]) begin
      rd_word[7:0] = empty ? 8'h00 : fifo_q[rd_ptr_q];
    end else if (address[3:2] == REG_CTRL[3:2]) begin
      rd_word[CTRL_RX_EN]  = rx_en_q;
      rd_word[CTRL_IRQ_EN] = irq_en;
    end
  end

  assign unused_wdata = ^wdata[31:3];

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_en_q     <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      byte_q      <= 8'h00;
      half_q      <= 16'h0;
      word_q      <= 32'h0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);

      if (ctrl_wr) begin
        rx_en_q <= wdata[CTRL_RX_EN];
        if (wdata[CTRL_CLEAR]) begin
          overflow_q  <= 1'b0;
          frame_err_q <= 1'b0;
        end
      end
      if (ovf_set)      overflow_q  <= 1'b1;
      if (rx_frame_err) frame_err_q <= 1'b1;

      done_q <= store_req;
      // Reads carry no size, so a read is flagged when its word view is misaligned.
      error_q <= in_win && ((write_mode == WM_NONE) ? (address[1:0] != 2'b00) : misalign);
      byte_q  <= in_win ? rd_word[{address[1:0], 3'b000} +: 8] : 8'h00;
      half_q  <= (in_win && !address[0]) ? rd_word[{address[1], 4'b0000} +: 16] : 16'h0;
      word_q  <= (in_win && address[1:0] == 2'b00) ? rd_word : 32'h0;
    end
  end

`ifdef PS2_KBD_IRQ_EN
  logic irq_en_q, irq_q;
  assign irq_en = irq_en_q;
  assign irq    = irq_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= wdata[CTRL_IRQ_EN];
      irq_q <= !empty && irq_en_q;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  assign byte_output      = byte_q;
  assign half_word_output = half_q;
  assign word_output      = word_q;
  assign done             = done_q;
  assign error            = error_q;

endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Directed bench for ps2_keyboard_mmio: bit-bangs PS/2 frames and checks registers via the bus.
module tb_ps2_keyboard_mmio;

  localparam logic [31:0] Base = 32'h0007_1000;
  localparam int unsigned Timeout = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [1:0]  write_mode;
  logic [7:0]  write_byte;
  logic [15:0] write_half_word;
  logic [31:0] write_word;
  logic [7:0]  byte_output;
  logic [15:0] half_word_output;
  logic [31:0] word_output;
  logic        done, error;
  logic        ps2_clk, ps2_dat;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [31:0] rd;

  ps2_keyboard_mmio #(
    .BASE_ADDR     (Base),
    .FIFO_DEPTH    (8),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .write_mode      (write_mode),
    .write_byte      (write_byte),
    .write_half_word (write_half_word),
    .write_word      (write_word),
    .byte_output     (byte_output),
    .half_word_output(half_word_output),
    .word_output     (word_output),
    .done            (done),
    .error           (error),
    .ps2_clk         (ps2_clk),
    .ps2_dat         (ps2_dat)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] w);
    address    = a;
    write_mode = 2'b00;
    tick();
    w = word_output;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] wm, input logic [31:0] d);
    address         = a;
    write_mode      = wm;
    write_byte      = d[7:0];
    write_half_word = d[15:0];
    write_word      = d;
    tick();
    write_mode = 2'b00;
    tick();
    tick();
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (8) tick();
    ps2_clk = 1'b0;
    repeat (8) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic ps2_frame(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~(^d) ^ bad_par);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (12) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    address = 32'h0;
    write_mode = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    write_byte = 8'h00;
    write_half_word = 16'h0;
    write_word = 32'h0;
    do_reset();
    check_eq("reset_word", word_output, 32'h0);
    check_eq("reset_flags", {30'h0, done, error}, 32'h0);
    read_reg(Base + 32'h8, rd);
    check_eq("reset_ctrl", rd, 32'h1);

    // 1: single frame 0x1C
    ps2_frame(8'h1C, 1'b0);
    read_reg(Base, rd);
    check_eq("t1_status", rd, 32'h0101);
    read_reg(Base + 32'h4, rd);
    check_eq("t1_data", rd, 32'h1C);

    // 2: store held 4 cycles pops exactly once
    ps2_frame(8'h32, 1'b0);
    address = Base + 32'h4;
    write_word = 32'h0;
    write_mode = 2'b11;
    check_eq("t2_done_pre", {31'h0, done}, 32'h0);
    tick();
    check_eq("t2_done_c1", {31'h0, done}, 32'h1);
    repeat (3) tick();
    check_eq("t2_done_c4", {31'h0, done}, 32'h1);
    write_mode = 2'b00;
    tick();
    check_eq("t2_done_drop", {31'h0, done}, 32'h0);
    read_reg(Base, rd);
    check_eq("t2_status_one", rd, 32'h0101);
    read_reg(Base + 32'h4, rd);
    check_eq("t2_data_second", rd, 32'h32);
    store(Base + 32'h4, 2'b01, 32'h0);
    read_reg(Base, rd);
    check_eq("t2_status_empty", rd, 32'h0);
    store(Base + 32'h4, 2'b11, 32'h0);
    read_reg(Base, rd);
    check_eq("t2_pop_empty", rd, 32'h0);
    read_reg(Base + 32'h4, rd);
    check_eq("t2_data_empty", rd, 32'h0);

    // 3: overflow with nine frames
    do_reset();
    for (int i = 0; i < 9; i++) ps2_frame(8'h10 + 8'(i), 1'b0);
    read_reg(Base, rd);
    check_eq("t3_status", rd, 32'h0807);
    read_reg(Base + 32'h4, rd);
    check_eq("t3_data", rd, 32'h10);
    store(Base + 32'h8, 2'b11, 32'h2);
    read_reg(Base, rd);
    check_eq("t3_status_clr", rd, 32'h0803);
    read_reg(Base + 32'h8, rd);
    check_eq("t3_ctrl", rd, 32'h0);

    // 4: bad parity, then a stalled frame, then a good one
    do_reset();
    ps2_frame(8'h55, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (Timeout + 20) tick();
    read_reg(Base, rd);
    check_eq("t4_status", rd, 32'h0008);
    ps2_frame(8'h29, 1'b0);
    read_reg(Base, rd);
    check_eq("t4_status_good", rd, 32'h0109);
    read_reg(Base + 32'h4, rd);
    check_eq("t4_data", rd, 32'h29);
    store(Base + 32'h8, 2'b11, 32'h3);
    read_reg(Base, rd);
    check_eq("t4_w1c", rd, 32'h0101);

    // 5: misaligned accesses and lanes
    read_reg(Base + 32'h2, rd);
    check_eq("t5_word_mis", rd, 32'h0);
    check_eq("t5_err_mis", {31'h0, error}, 32'h1);
    address = Base + 32'h1;
    tick();
    check_eq("t5_byte_lane", {24'h0, byte_output}, 32'h01);
    address = Base;
    tick();
    check_eq("t5_half", {16'h0, half_word_output}, 32'h0101);
    check_eq("t5_err_ok", {31'h0, error}, 32'h0);
    address = Base + 32'h6;
    write_word = 32'h0;
    write_mode = 2'b11;
    tick();
    check_eq("t5_store_flags", {30'h0, done, error}, 32'h3);
    write_mode = 2'b00;
    tick();
    read_reg(Base, rd);
    check_eq("t5_no_pop", rd, 32'h0101);
    read_reg(Base + 32'h10, rd);
    check_eq("t5_out_window", rd, 32'h0);
    read_reg(Base + 32'hC, rd);
    check_eq("t5_reg_c", rd, 32'h0);

    // 6: reset mid-frame
    do_reset();
    ps2_frame(8'h11, 1'b0);
    ps2_frame(8'h22, 1'b0);
    ps2_frame(8'h33, 1'b0);
    read_reg(Base, rd);
    check_eq("t6_pre", rd, 32'h0301);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b0;
    #1;
    check_eq("t6_rst_word", word_output, 32'h0);
    check_eq("t6_rst_misc", {6'h0, half_word_output, byte_output, done, error}, 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    read_reg(Base, rd);
    check_eq("t6_status", rd, 32'h0);
    read_reg(Base + 32'h8, rd);
    check_eq("t6_ctrl", rd, 32'h1);
    ps2_frame(8'h1C, 1'b0);
    read_reg(Base + 32'h4, rd);
    check_eq("t6_after", rd, 32'h1C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
